// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: arbitrary depth, fill level, almost thresholds, 1-cycle read strobe.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags (cleared by err_clr).
module sync_fifo_ctrl #(
  parameter int DATA_LEN   = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_LEN-1:0]   data_in,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_LEN-1:0]   data_out,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]         DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]         AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0]         AE_L    = LW'(AE_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_LEN-1:0]   mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_LEN-1:0]   data_out_q;
  logic                  rd_valid_q, empty_q, full_q, ae_q, af_q, ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Explicit wrap compare keeps non-power-of-two depths correct.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    if (wr_acc && !rd_acc)      level_d = level_q + LW'(1);
    else if (rd_acc && !wr_acc) level_d = level_q - LW'(1);
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Set has priority over clear on the same edge.
  assign ovf_d = (wr_en && full_q)  || (ovf_q && !err_clr);
  assign udf_d = (rd_en && empty_q) || (udf_q && !err_clr);
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf_d = 1'b0;
  assign udf_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ae_q       <= 1'b1;
      af_q       <= (AF_LEVEL == 0);
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= mem[rd_ptr_q];
      empty_q    <= (level_d == '0);
      full_q     <= (level_d == DEPTH_L);
      ae_q       <= (level_d <= AE_L);
      af_q       <= (level_d >= AF_L);
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (sys_rst_n && wr_acc) mem[wr_ptr_q] <= data_in;
  end

  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign level        = level_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised single-clock FIFO that buffers matrix/vector words between EKF pipeline stages. It supports arbitrary (non-power-of-two) depth, a fill-level output, programmable almost-full/almost-empty thresholds and a one-cycle read-valid strobe. Accept logic is exact: the FIFO state changes only on accepted reads and writes. It sits between producer and consumer datapath blocks in the same clock domain.

## Interface
- DATA_LEN, 8, word width in bits
- DEPTH, 8, number of storage words, 2..2^ADDR_WIDTH, need not be a power of two
- ADDR_WIDTH, 3, pointer width; 2^ADDR_WIDTH >= DEPTH
- AF_LEVEL, DEPTH-1, almost_full asserted when level >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when level <= AE_LEVEL
- clk  input  1  clock, all logic on rising edge
- sys_rst_n  input  1  reset, synchronous, active-low
- wr_en  input  1  write request
- data_in  input  DATA_LEN  write data
- rd_en  input  1  read request
- err_clr  input  1  clears sticky error flags
- data_out  output  DATA_LEN  read data, registered
- rd_valid  output  1  data_out carries a newly read word this cycle
- level  output  ADDR_WIDTH+1  current word count, 0..DEPTH
- empty  output  1  level == 0
- full  output  1  level == DEPTH
- almost_empty  output  1  level <= AE_LEVEL
- almost_full  output  1  level >= AF_LEVEL
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Write is accepted when wr_en && !full. An accepted write stores data_in at wr_addr, and wr_addr advances.
- Read is accepted when rd_en && !empty. An accepted read loads mem[rd_addr] into data_out, and rd_addr advances.
- Pointers wrap from DEPTH-1 to 0. No power-of-two arithmetic is used.
- Level updates per edge:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted, or neither is.
  - Level never leaves 0..DEPTH.
- Simultaneous requests:
  - When full, the read is accepted and the write is rejected: level becomes DEPTH-1, and data_in is dropped.
  - When empty, the write is accepted and the read is rejected: level becomes 1, and rd_valid stays 0.
  - When neither full nor empty, both are accepted and level is unchanged.
- Status outputs (empty, full, almost_empty, almost_full) are registered. Each is a function of the level register, so all change on the same edge as level.
- data_out holds its last value when no read is accepted. It is not zeroed.
- Storage array is not reset, so it can infer as RAM. Contents are undefined until written.

## Timing
- Reset: when sys_rst_n is low at a rising edge, the next state is:
  - pointers = 0, level = 0
  - data_out = 0, rd_valid = 0
  - empty = 1, almost_empty = 1, full = 0
  - almost_full = (AF_LEVEL == 0)
  - overflow = 0, underflow = 0
  - Requests in that cycle are ignored.
  - Reset mid-operation discards all buffered words.
- Read latency is 1 cycle: rd_en accepted at edge N gives data_out valid and rd_valid = 1 after edge N, for exactly one cycle per accepted read.
- Write-to-read: a word written at edge N deasserts empty after edge N. The earliest accepted read is at edge N+1, with data available after N+1.
- full deasserts the cycle after an accepted read. Back-to-back reads and writes sustain 1 word/cycle each.

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN defined:
  - overflow sets on any edge with wr_en && full.
  - underflow sets on any edge with rd_en && empty.
  - Both remain set until err_clr is sampled high or reset. If set and clear occur on the same edge, set wins.
- Not defined: overflow and underflow are constant 0, and err_clr is ignored. Port list is unchanged.

## Test plan
- Reset, then 8 writes 0x01..0x08 (DEPTH=8): level steps 1..8; full=1 after the 8th; almost_full=1 after the 7th. A 9th write of 0xFF is dropped, and overflow=1 with the macro.
- Read 8 words from full: data_out = 0x01..0x08 in order, rd_valid high each cycle; empty=1 after the last. A 9th rd_en gives rd_valid=0 and underflow=1.
- DEPTH=5, ADDR_WIDTH=3: stream 12 words with interleaved reads. Pointers wrap 4->0, and output order matches input.
- Full + wr_en && rd_en: level becomes 7, the write is dropped, and the oldest word is output. Empty + both: level becomes 1, rd_valid=0.
- Half full, continuous wr_en && rd_en for 20 cycles: level constant at 4, rd_valid every cycle, data in order.
- sys_rst_n low for one cycle with level=5: all outputs return to reset values. A subsequent write/read of 0xA5 is returned correctly.
